// File: rtl/multi_channel_pit.sv
// N-channel programmable interval timer: per-channel prescaled down-counters with
// one-shot/periodic modes, sticky pending/overrun flags and a masked, OR'd interrupt line.
module multi_channel_pit #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PRE_W  = 8,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [1:0]        wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_count,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun,
  output logic              irq
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [CH_W:0] NumChW = (CH_W + 1)'(NUM_CH);

  logic [CNT_W-1:0]  counts [NUM_CH];
  logic [NUM_CH-1:0] mask;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] reload_q;
    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] pcnt_q;
    logic [3:0]       ctrl_q;  // {mask, presc_en, periodic, enable}
    logic             pending_q;
    logic             overrun_q;
    logic             sel;
    logic             wr_ctrl;
    logic             wr_reload;
    logic             wr_presc;
    logic             wr_ack;
    logic             tick;
    logic             expire;

    assign sel       = wr_en && (wr_ch == CH_W'(c));
    assign wr_ctrl   = sel && (wr_addr == 2'd0);
    assign wr_reload = sel && (wr_addr == 2'd1);
    assign wr_presc  = sel && (wr_addr == 2'd2);
    assign wr_ack    = sel && (wr_addr == 2'd3);

    assign tick   = (state_q == StRun) && (!ctrl_q[2] || (pcnt_q == presc_q));
    // A CTRL write in the expiry cycle takes priority and suppresses the expiry.
    assign expire = tick && (count_q == '0) && !wr_ctrl;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= StIdle;
        count_q   <= '0;
        reload_q  <= '0;
        presc_q   <= '0;
        pcnt_q    <= '0;
        ctrl_q    <= '0;
        pending_q <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        if (wr_reload) reload_q <= wr_data;
        if (wr_presc)  presc_q  <= wr_data[PRE_W-1:0];

        if (wr_ctrl) begin
          ctrl_q <= wr_data[3:0];
          if (wr_data[0]) begin
            state_q <= StRun;
            count_q <= reload_q;
            pcnt_q  <= '0;
          end else begin
            state_q <= StIdle;
          end
        end else if (state_q == StRun) begin
          if (ctrl_q[2]) pcnt_q <= (pcnt_q == presc_q) ? '0 : pcnt_q + 1'b1;
          if (tick) begin
            if (count_q != '0) begin
              count_q <= count_q - 1'b1;
            end else if (ctrl_q[1]) begin
              count_q <= reload_q;
            end else begin
              state_q   <= StIdle;
              ctrl_q[0] <= 1'b0;
            end
          end
        end

        pending_q <= (pending_q & ~(wr_ack & wr_data[0])) | expire;
        overrun_q <= (overrun_q & ~(wr_ack & wr_data[1])) | (expire & pending_q);
      end
    end

    assign counts[c]  = count_q;
    assign running[c] = (state_q == StRun);
    assign pending[c] = pending_q;
    assign overrun[c] = overrun_q;
    assign mask[c]    = ctrl_q[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      irq      <= 1'b0;
    end else begin
      rd_count <= ({1'b0, rd_ch} < NumChW) ? counts[rd_ch] : '0;
      irq      <= |(pending & mask);
    end
  end

endmodule
